alu_exec_stage: RTL

//  Execute stage of the RV32I pipeline; sits directly downstream of the ALU decoder.
//  - Accepts decoded ALUop, two operands and writeback tag through a valid/ready handshake.
//  - Computes the ALU result and holds it in an output register for the writeback stage.
//  - A 2-entry skid buffer keeps in_ready registered, so downstream backpressure never

---
 rtl/alu_exec_stage_pkg.sv | 29 ++
 rtl/alu_exec_stage_alu.sv | 49 ++++
 rtl/alu_exec_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_exec_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_stage_pkg
// Shared definitions for the RV32I execute stage.
//   - ALUop encodings (mirrors ALUop.vh: ADD=0 .. COPY_B=10, XXX=15)
//   - occ_e: occupancy of the two-entry skid buffer
// -----------------------------------------------------------------------------
package alu_exec_stage_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLT    = 4'd5;
    localparam logic [3:0] ALU_SLTU   = 4'd6;
    localparam logic [3:0] ALU_SLL    = 4'd7;
    localparam logic [3:0] ALU_SRA    = 4'd8;
    localparam logic [3:0] ALU_SRL    = 4'd9;
    localparam logic [3:0] ALU_COPY_B = 4'd10;
    localparam logic [3:0] ALU_XXX    = 4'd15;

    // EMPTY: nothing held; ONE: MAIN valid; TWO: MAIN and SKID valid.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/alu_exec_stage_alu.sv
// -----------------------------------------------------------------------------
// alu_exec_stage_alu
// Purely combinational RV32I ALU. All arithmetic is modulo 2^XLEN.
// Ports:
//   aluop_i   [3:0]      ALUop encoding
//   a_i       [XLEN-1:0] operand A
//   b_i       [XLEN-1:0] operand B (low $clog2(XLEN) bits are the shift amount)
//   result_o  [XLEN-1:0] result; 0 for ALU_XXX / undefined encodings
//   illegal_o            1 for ALU_XXX / undefined encodings
// -----------------------------------------------------------------------------
module alu_exec_stage_alu #(
    parameter int XLEN = 32
) (
    input  logic [3:0]      aluop_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o
);
    import alu_exec_stage_pkg::*;

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = b_i[SHW-1:0];

    // NOTE: every output gets a default before the case, so no path through
    // this block can leave a value unassigned and infer a latch.
    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        case (aluop_i)
            ALU_ADD:    result_o = a_i + b_i;
            ALU_SUB:    result_o = a_i - b_i;
            ALU_AND:    result_o = a_i & b_i;
            ALU_OR:     result_o = a_i | b_i;
            ALU_XOR:    result_o = a_i ^ b_i;
            ALU_SLT:    result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU:   result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_SLL:    result_o = a_i << shamt;
            ALU_SRL:    result_o = a_i >> shamt;
            // The operand must be signed for >>> to sign-fill.
            ALU_SRA:    result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_COPY_B: result_o = b_i;
            default:    illegal_o = 1'b1;   // ALU_XXX and unused codes
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
// Execute stage of the RV32I pipeline. Accepts a decoded op via valid/ready,
// computes the ALU result on entry and holds it in an output register. A
// second (SKID) entry lets in_ready come straight from a flop, so out_ready
// never reaches the decoder combinationally.
// Ports:
//   clk, reset (async, active-high), flush (sync kill of all held entries)
//   in_valid / in_ready (registered), in_aluop, in_a, in_b, in_rd, in_we
//   out_valid / out_ready, out_result, out_rd,
//   out_we (forced 0 for rd==0 or illegal ops), out_illegal
// -----------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_aluop,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_rd,
    input  logic             in_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_rd,
    output logic             out_we,
    output logic             out_illegal
);
    import alu_exec_stage_pkg::*;

    occ_e state_q, state_d;
    logic in_ready_q, in_ready_d;

    logic [XLEN-1:0]  main_result_q, skid_result_q;
    logic [TAG_W-1:0] main_rd_q,     skid_rd_q;
    logic             main_we_q,     skid_we_q;
    logic             main_ill_q,    skid_ill_q;

    logic [XLEN-1:0] alu_result;
    logic            alu_illegal;
    logic            new_we;

    logic accept, drain;
    logic load_main_in, load_main_skid, load_skid_in;

    alu_exec_stage_alu #(.XLEN(XLEN)) u_alu (
        .aluop_i   (in_aluop),
        .a_i       (in_a),
        .b_i       (in_b),
        .result_o  (alu_result),
        .illegal_o (alu_illegal)
    );

    // Writes to x0 and illegal ops never reach the register file.
    assign new_we = in_we && (in_rd != '0) && !alu_illegal;

    assign out_valid = (state_q != OCC_EMPTY);
    assign accept    = in_valid && in_ready_q && !flush;
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        state_d      = OCC_ONE;
                        load_main_in = 1'b1;
                    end
                end
                OCC_ONE: begin
                    case ({accept, drain})
                        2'b10: begin
                            state_d      = OCC_TWO;
                            load_skid_in = 1'b1;
                        end
                        2'b01:   state_d      = OCC_EMPTY;
                        2'b11:   load_main_in = 1'b1;   // MAIN leaves and is refilled
                        default: ;
                    endcase
                end
                OCC_TWO: begin
                    // in_ready is low here, so accept cannot occur.
                    if (drain) begin
                        state_d        = OCC_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    // in_ready is precomputed from the next state so it is a flop output.
    assign in_ready_d = (state_d != OCC_TWO);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the data entries are reset as well, because out_result/out_rd/
    // out_we/out_illegal must read zero while reset is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= OCC_EMPTY;
            in_ready_q    <= 1'b1;
            main_result_q <= '0;
            main_rd_q     <= '0;
            main_we_q     <= 1'b0;
            main_ill_q    <= 1'b0;
            skid_result_q <= '0;
            skid_rd_q     <= '0;
            skid_we_q     <= 1'b0;
            skid_ill_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            if (load_main_in) begin
                main_result_q <= alu_result;
                main_rd_q     <= in_rd;
                main_we_q     <= new_we;
                main_ill_q    <= alu_illegal;
            end else if (load_main_skid) begin
                main_result_q <= skid_result_q;
                main_rd_q     <= skid_rd_q;
                main_we_q     <= skid_we_q;
                main_ill_q    <= skid_ill_q;
            end
            if (load_skid_in) begin
                skid_result_q <= alu_result;
                skid_rd_q     <= in_rd;
                skid_we_q     <= new_we;
                skid_ill_q    <= alu_illegal;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_result  = main_result_q;
    assign out_rd      = main_rd_q;
    assign out_we      = main_we_q;
    assign out_illegal = main_ill_q;

endmodule
